// File: rtl/routine_sequencer.sv
// Steps four display routines onto the board LEDs and displays, with a short blank gap between them.
// Define ROUTINE_SEQUENCER_PREV_EN to add a Prev button that steps backwards through the routines.
module routine_sequencer #(
    parameter int TICK_DIV     = 25000000,
    parameter int DWELL_TICKS  = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Next,
`ifdef ROUTINE_SEQUENCER_PREV_EN
    input  logic        Prev,
`endif
    input  logic        Auto,
    input  logic [45:0] Routine0Bus,
    input  logic [45:0] Routine1Bus,
    input  logic [45:0] Routine2Bus,
    input  logic [45:0] Routine3Bus,
    output logic [3:0]  RoutineRun,
    output logic        RoutineTick,
    output logic [45:0] OutputBus,
    output logic [1:0]  Selected
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        RUN   = 1'b1
    } seqState_t;

    seqState_t       state;
    seqState_t       stateNext;
    logic [TW-1:0]   tickCount;
    logic [DW-1:0]   dwellCount;
    logic [DW-1:0]   dwellNext;
    logic [BW-1:0]   blankCount;
    logic [BW-1:0]   blankNext;
    logic [1:0]      selectedNext;
    logic [45:0]     selectedBus;
    logic            dwellExpire;

    logic [1:0]      primeCount;
    logic            primed;
    logic            nextMeta;
    logic            nextSync;
    logic            nextDly;
    logic            nextPulse;
    logic            prevPulse;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tickCount <= '0;
        end else if (tickCount == TICK_LAST) begin
            tickCount <= '0;
        end else begin
            tickCount <= tickCount + 1'b1;
        end
    end

    assign RoutineTick = (tickCount == TICK_LAST);

    // Edges are ignored until the edge flop holds a real sample, so a button
    // held through reset release does not look like a fresh press.
    assign primed = (primeCount == 2'd3);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            primeCount <= '0;
            nextMeta   <= 1'b0;
            nextSync   <= 1'b0;
            nextDly    <= 1'b0;
            nextPulse  <= 1'b0;
        end else begin
            if (!primed) begin
                primeCount <= primeCount + 2'd1;
            end
            nextMeta  <= Next;
            nextSync  <= nextMeta;
            nextDly   <= nextSync;
            nextPulse <= primed & nextSync & ~nextDly;
        end
    end

`ifdef ROUTINE_SEQUENCER_PREV_EN
    logic prevMeta;
    logic prevSync;
    logic prevDly;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prevMeta  <= 1'b0;
            prevSync  <= 1'b0;
            prevDly   <= 1'b0;
            prevPulse <= 1'b0;
        end else begin
            prevMeta  <= Prev;
            prevSync  <= prevMeta;
            prevDly   <= prevSync;
            prevPulse <= primed & prevSync & ~prevDly;
        end
    end
`else
    assign prevPulse = 1'b0;
`endif

    always_comb begin
        selectedBus = Routine0Bus;
        case (Selected)
            2'd0: selectedBus = Routine0Bus;
            2'd1: selectedBus = Routine1Bus;
            2'd2: selectedBus = Routine2Bus;
            2'd3: selectedBus = Routine3Bus;
            default: selectedBus = Routine0Bus;
        endcase
    end

    assign dwellExpire = Auto && (dwellCount == DWELL_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= BLANK;
            Selected   <= 2'd0;
            blankCount <= '0;
            dwellCount <= '0;
            OutputBus  <= '0;
        end else begin
            state      <= stateNext;
            Selected   <= selectedNext;
            blankCount <= blankNext;
            dwellCount <= dwellNext;
            OutputBus  <= (state == RUN) ? selectedBus : '0;
        end
    end

    // Auto expiry always wins as a single +1 step; opposing button presses in
    // the same cycle cancel each other out.
    always_comb begin
        stateNext    = state;
        selectedNext = Selected;
        blankNext    = blankCount;
        dwellNext    = dwellCount;
        RoutineRun   = 4'b0000;
        case (state)
            BLANK: begin
                dwellNext = '0;
                if (blankCount == BLANK_LAST) begin
                    blankNext = '0;
                    stateNext = RUN;
                end else begin
                    blankNext = blankCount + 1'b1;
                end
            end
            RUN: begin
                RoutineRun = 4'b0001 << Selected;
                if (!Auto) begin
                    dwellNext = '0;
                end else if (RoutineTick) begin
                    dwellNext = dwellCount + 1'b1;
                end
                if (dwellExpire || (nextPulse && !prevPulse)) begin
                    selectedNext = Selected + 2'd1;
                    stateNext    = BLANK;
                    dwellNext    = '0;
                    blankNext    = '0;
                end else if (prevPulse && !nextPulse) begin
                    selectedNext = Selected - 2'd1;
                    stateNext    = BLANK;
                    dwellNext    = '0;
                    blankNext    = '0;
                end
            end
            default: begin
                stateNext = BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_routine_sequencer.sv
// Directed self-checking bench for routine_sequencer with TICK_DIV=4, DWELL_TICKS=2, BLANK_CYCLES=4.
// Exercises the Prev button as well when ROUTINE_SEQUENCER_PREV_EN is defined.
module tb_routine_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int DWELL_TICKS  = 2;
    localparam int BLANK_CYCLES = 4;

    localparam logic [45:0] BUS0 = 46'h0123_4567_89AB;
    localparam logic [45:0] BUS1 = 46'h1111_2222_3333;
    localparam logic [45:0] BUS2 = 46'h2AAA_5555_0F0F;
    localparam logic [45:0] BUS3 = 46'h3FFF_0000_FFFF;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Next;
    logic        Auto;
`ifdef ROUTINE_SEQUENCER_PREV_EN
    logic        Prev;
`endif
    logic [3:0]  RoutineRun;
    logic        RoutineTick;
    logic [45:0] OutputBus;
    logic [1:0]  Selected;

    int edgeCount;
    int checks;
    int passes;

    routine_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Next       (Next),
`ifdef ROUTINE_SEQUENCER_PREV_EN
        .Prev       (Prev),
`endif
        .Auto       (Auto),
        .Routine0Bus(BUS0),
        .Routine1Bus(BUS1),
        .Routine2Bus(BUS2),
        .Routine3Bus(BUS3),
        .RoutineRun (RoutineRun),
        .RoutineTick(RoutineTick),
        .OutputBus  (OutputBus),
        .Selected   (Selected)
    );

    always #5 Clock = ~Clock;

    function automatic logic [45:0] busOf(input logic [1:0] sel);
        case (sel)
            2'd0: return BUS0;
            2'd1: return BUS1;
            2'd2: return BUS2;
            default: return BUS3;
        endcase
    endfunction

    function automatic logic [3:0] oneHot(input logic [1:0] sel);
        case (sel)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s at edge %0d: observed %h expected %h", tag, edgeCount, observed, expected);
        end else begin
            passes++;
        end
    endtask

    // Advances one clock and samples just after the edge; the tick strobe is
    // predicted from the number of edges since reset release.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
            if (!Reset) begin
                edgeCount++;
            end
            checkOutput("tick", 64'(RoutineTick), 64'((edgeCount % TICK_DIV) == (TICK_DIV - 1)));
        end
    endtask

    task automatic stepTo(input int target);
        while (edgeCount < target) begin
            stepCycles(1);
        end
    endtask

    // Caller raises the button just after an edge; the pulse appears three
    // edges later and the advance lands on the fourth.
    task automatic applyStimulus(input logic [1:0] oldSel, input logic [1:0] newSel);
        stepCycles(3);
        checkOutput("sel_hold", 64'(Selected), 64'(oldSel));
        checkOutput("run_hold", 64'(RoutineRun), 64'(oneHot(oldSel)));
        stepCycles(1);
        checkOutput("sel_step", 64'(Selected), 64'(newSel));
        checkOutput("run_blank", 64'(RoutineRun), 64'd0);
        checkOutput("bus_last", 64'(OutputBus), 64'(busOf(oldSel)));
        Next = 1'b0;
`ifdef ROUTINE_SEQUENCER_PREV_EN
        Prev = 1'b0;
`endif
        for (int i = 0; i < BLANK_CYCLES; i++) begin
            stepCycles(1);
            checkOutput("bus_gap", 64'(OutputBus), 64'd0);
        end
        checkOutput("run_new", 64'(RoutineRun), 64'(oneHot(newSel)));
        stepCycles(1);
        checkOutput("bus_new", 64'(OutputBus), 64'(busOf(newSel)));
    endtask

    initial begin
        int first;
        int second;
        checks    = 0;
        passes    = 0;
        edgeCount = 0;
        Reset     = 1'b1;
        Next      = 1'b0;
        Auto      = 1'b0;
`ifdef ROUTINE_SEQUENCER_PREV_EN
        Prev      = 1'b0;
`endif
        #2;
        checkOutput("rst_bus", 64'(OutputBus), 64'd0);
        checkOutput("rst_run", 64'(RoutineRun), 64'd0);
        checkOutput("rst_sel", 64'(Selected), 64'd0);
        checkOutput("rst_tick", 64'(RoutineTick), 64'd0);
        @(posedge Clock);
        #3;
        Reset = 1'b0;

        // Power-up blank window then routine 0
        checkOutput("pwr_bus", 64'(OutputBus), 64'd0);
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput("pwr_run", 64'(RoutineRun), 64'd0);
            checkOutput("pwr_bus", 64'(OutputBus), 64'd0);
        end
        stepCycles(1);
        checkOutput("pwr_run0", 64'(RoutineRun), 64'b0001);
        checkOutput("pwr_bus", 64'(OutputBus), 64'd0);
        stepCycles(1);
        checkOutput("pwr_bus0", 64'(OutputBus), 64'(BUS0));
        checkOutput("pwr_sel", 64'(Selected), 64'd0);

        // Four Next presses walk 1,2,3 and wrap to 0
        for (int i = 0; i < 4; i++) begin
            stepCycles(2);
            Next = 1'b1;
            applyStimulus(2'(i), 2'(i + 1));
        end

        // Second Next edge lands while blanking and must be dropped
        Next = 1'b1;
        stepCycles(1);
        Next = 1'b0;
        stepCycles(1);
        Next = 1'b1;
        stepCycles(1);
        checkOutput("bp_hold", 64'(Selected), 64'd0);
        stepCycles(1);
        checkOutput("bp_step", 64'(Selected), 64'd1);
        Next = 1'b0;
        stepCycles(3);
        checkOutput("bp_sel", 64'(Selected), 64'd1);
        checkOutput("bp_run0", 64'(RoutineRun), 64'd0);
        stepCycles(1);
        checkOutput("bp_run", 64'(RoutineRun), 64'b0010);
        stepCycles(3);
        checkOutput("bp_sel2", 64'(Selected), 64'd1);

        // Auto advance after the second tick in RUN
        Auto   = 1'b1;
        first  = (edgeCount / TICK_DIV + 1) * TICK_DIV;
        second = first + TICK_DIV;
        stepTo(second);
        checkOutput("auto_hold", 64'(Selected), 64'd1);
        checkOutput("auto_run", 64'(RoutineRun), 64'b0010);
        stepTo(second + 1);
        checkOutput("auto_step", 64'(Selected), 64'd2);
        checkOutput("auto_blank", 64'(RoutineRun), 64'd0);
        Auto = 1'b0;
        stepCycles(BLANK_CYCLES);
        checkOutput("auto_run2", 64'(RoutineRun), 64'b0100);

        // Asynchronous reset between edges with Next held across release
        #3;
        Reset     = 1'b1;
        edgeCount = 0;
        #1;
        checkOutput("ar_bus", 64'(OutputBus), 64'd0);
        checkOutput("ar_run", 64'(RoutineRun), 64'd0);
        checkOutput("ar_sel", 64'(Selected), 64'd0);
        checkOutput("ar_tick", 64'(RoutineTick), 64'd0);
        Next = 1'b1;
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        stepCycles(3);
        checkOutput("ar_blank", 64'(RoutineRun), 64'd0);
        stepCycles(1);
        checkOutput("ar_run0", 64'(RoutineRun), 64'b0001);
        stepCycles(6);
        checkOutput("ar_noadv", 64'(Selected), 64'd0);
        checkOutput("ar_run1", 64'(RoutineRun), 64'b0001);
        checkOutput("ar_bus0", 64'(OutputBus), 64'(BUS0));
        Next = 1'b0;
        stepCycles(3);

        // Next pulse coinciding with dwell expiry gives one step only
        Auto   = 1'b1;
        first  = (edgeCount / TICK_DIV + 1) * TICK_DIV;
        second = first + TICK_DIV;
        stepTo(second - 3);
        Next = 1'b1;
        stepCycles(1);
        Next = 1'b0;
        stepTo(second);
        checkOutput("co_hold", 64'(Selected), 64'd0);
        stepTo(second + 1);
        checkOutput("co_step", 64'(Selected), 64'd1);
        Auto = 1'b0;
        stepCycles(6);
        checkOutput("co_once", 64'(Selected), 64'd1);
        checkOutput("co_run", 64'(RoutineRun), 64'b0010);

`ifdef ROUTINE_SEQUENCER_PREV_EN
        // Prev wraps 0 to 3; simultaneous Next and Prev do nothing
        #3;
        Reset     = 1'b1;
        edgeCount = 0;
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        stepCycles(BLANK_CYCLES + 3);
        checkOutput("pv_sel0", 64'(Selected), 64'd0);
        Prev = 1'b1;
        applyStimulus(2'd0, 2'd3);
        Next = 1'b1;
        Prev = 1'b1;
        stepCycles(1);
        Next = 1'b0;
        Prev = 1'b0;
        stepCycles(4);
        checkOutput("pv_both_sel", 64'(Selected), 64'd3);
        checkOutput("pv_both_run", 64'(RoutineRun), 64'b1000);
        stepCycles(3);
        checkOutput("pv_both_sel2", 64'(Selected), 64'd3);
        checkOutput("pv_both_bus", 64'(OutputBus), 64'(BUS3));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/routine_sequencer.md
ROUTINE_SEQUENCER -- requirements
Module: routine_sequencer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 25000000, Clock cycles per RoutineTick strobe (>=2).
REQ-002 SHALL provide parameter DWELL_TICKS, default 16, RoutineTick strobes per routine in auto mode (>=1).
REQ-003 SHALL provide parameter BLANK_CYCLES, default 4, Clock cycles of blank output between routines (>=1).
REQ-004 Clock  in  1  single system clock; all flops on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 Next  in  1  raw asynchronous pushbutton, active-high; advances to the next routine.
REQ-007 Auto  in  1  level; 1 = advance automatically after DWELL_TICKS.
REQ-008 Routine0Bus..Routine3Bus  in  46 each  routine output buses: [45:36] red, [35:28] green, [27:0] Hex3..Hex0.
REQ-009 RoutineRun  out  4  one-hot run enable per routine; 0 holds that routine in its cleared state.
REQ-010 RoutineTick  out  1  one-cycle strobe every TICK_DIV cycles, routine advance enable.
REQ-011 OutputBus  out  46  registered bus to board LEDs and displays.
REQ-012 Selected  out  2  index of the current routine.

Function
REQ-013 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert RoutineTick for exactly the cycle in which count == TICK_DIV-1, in every FSM state.
REQ-014 Next SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-cycle NextPulse (3-cycle input-to-pulse latency).
REQ-015 FSM SHALL have two states: BLANK and RUN.
REQ-016 BLANK: OutputBus = 0, RoutineRun = 0; blank counter counts BLANK_CYCLES cycles, then FSM SHALL enter RUN.
REQ-017 RUN: RoutineRun = one-hot of Selected; OutputBus SHALL be the selected RoutineNBus registered with 1-cycle latency.
REQ-018 Dwell counter SHALL increment on RoutineTick only in RUN with Auto = 1; it SHALL clear whenever Auto = 0 or the FSM is in BLANK.
REQ-019 Advance event SHALL be NextPulse in RUN, or Auto = 1 with dwell counter reaching DWELL_TICKS.
REQ-020 On advance: Selected <= Selected+1 mod 4 (3 wraps to 0), dwell counter cleared, FSM -> BLANK next cycle.
REQ-021 NextPulse and dwell expiry in the same cycle SHALL produce one advance only.
REQ-022 NextPulse during BLANK SHALL be discarded; Selected unchanged, blank count not restarted.
REQ-023 Auto toggled mid-dwell SHALL restart dwell from 0 on next assertion.

Reset
REQ-024 Reset SHALL asynchronously force: state BLANK, Selected = 0, blank/dwell/tick counters = 0, synchronizer and edge flops = 0, OutputBus = 0, RoutineRun = 0, RoutineTick = 0.
REQ-025 Reset asserted mid-RUN or mid-BLANK SHALL take effect without waiting for a clock edge; after release the block SHALL re-enter RUN with Selected = 0 after BLANK_CYCLES cycles.
REQ-026 A Next held high through Reset release SHALL NOT generate a NextPulse.

Configuration
REQ-027 With macro ROUTINE_SEQUENCER_PREV_EN defined, the block SHALL add input Prev (1 bit, raw button), synchronized and edge-detected as Next, which decrements Selected mod 4 (0 wraps to 3) and enters BLANK, with dwell cleared.
REQ-028 With ROUTINE_SEQUENCER_PREV_EN defined, simultaneous NextPulse and PrevPulse SHALL cause no change and no blank; auto expiry in that cycle SHALL still advance by +1.
REQ-029 Without ROUTINE_SEQUENCER_PREV_EN, port Prev SHALL NOT exist and behaviour SHALL be REQ-013..REQ-026 only.

Verification (TICK_DIV=4, DWELL_TICKS=2, BLANK_CYCLES=4)
REQ-030 Reset release, Auto=0 -> OutputBus=0 for 4 cycles, then RoutineRun=4'b0001 and OutputBus=Routine0Bus one cycle later; RoutineTick every 4th cycle.
REQ-031 Next pulsed 4 times in RUN -> Selected 1,2,3,0; RoutineRun 0010,0100,1000,0001; each change preceded by a 4-cycle OutputBus=0 gap.
REQ-032 Auto=1 in RUN -> advance after the 2nd RoutineTick; Next edge coinciding with expiry -> Selected increments by exactly 1.
REQ-033 Next edge during BLANK -> Selected unchanged, RUN entered at the original 4-cycle point.
REQ-034 Reset pulsed between clock edges mid-RUN with Selected=2 -> OutputBus=0, RoutineRun=0, Selected=0 immediately; Next held high across release -> no advance.
REQ-035 With ROUTINE_SEQUENCER_PREV_EN: Prev from Selected=0 -> Selected=3; Next and Prev edges in the same cycle -> Selected unchanged, no blank.
